alu_muldiv_seq: RTL

Multi-cycle multiply/divide sequencer that reuses the pipeline's single 16-bit ALU instead of adding a dedicated multiplier or divider. It sits beside the EX stage and owns the ALU's input port. When idle, it passes the EX-stage operands straight through to the ALU. When a MUL/DIV is accepted, it takes the ALU over, iterates shift-add or restoring-divide steps through it, and stalls the pipeline until the result is ready.

---
 rtl/mips16_pkg.sv | 23 ++
 rtl/alu_port_mux.sv | 21 ++
 rtl/alu_muldiv_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: datapath widths, ALU opcodes and the mul/div sequencer states.
package mips16_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CTL_W  = 3;
   localparam int unsigned CNT_W  = 4;

   localparam logic [CTL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [CTL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [CTL_W-1:0] ALU_AND = 3'b010;
   localparam logic [CTL_W-1:0] ALU_OR  = 3'b011;
   localparam logic [CTL_W-1:0] ALU_SLT = 3'b100;
   localparam logic [CTL_W-1:0] ALU_LUI = 3'b110;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MUL     = 3'd1,
      DIV_CMP = 3'd2,
      DIV_SUB = 3'd3,
      DONE    = 3'd4
   } muldiv_state_t;

endpackage

// File: rtl/alu_port_mux.sv
// Owner select for the shared ALU input port: EX stage when idle, sequencer otherwise.
module alu_port_mux
   import mips16_pkg::*;
(
   input  logic              seq_own,
   input  logic [DATA_W-1:0] ex_in1,
   input  logic [DATA_W-1:0] ex_in2,
   input  logic [CTL_W-1:0]  ex_ctl,
   input  logic [DATA_W-1:0] seq_in1,
   input  logic [DATA_W-1:0] seq_in2,
   input  logic [CTL_W-1:0]  seq_ctl,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [CTL_W-1:0]  alu_ctl
);

   assign alu_in1 = seq_own ? seq_in1 : ex_in1;
   assign alu_in2 = seq_own ? seq_in2 : ex_in2;
   assign alu_ctl = seq_own ? seq_ctl : ex_ctl;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle multiply / unsigned divide sequencer that borrows the pipeline's shared ALU
// for shift-add and restoring-divide steps, stalling the pipeline while it works.
module alu_muldiv_seq
   import mips16_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              op_div,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   input  logic [DATA_W-1:0] ex_in1,
   input  logic [DATA_W-1:0] ex_in2,
   input  logic [CTL_W-1:0]  ex_ctl,
   input  logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic [CTL_W-1:0]  alu_ctl,
   output logic [DATA_W-1:0] ex_result,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] res_q,
   output logic [DATA_W-1:0] res_r
);

   muldiv_state_t state_q, state_d;

   // a: multiplicand / dividend, b: multiplier / divisor, acc: product / partial remainder
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, quo_q, quo_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d, lt_q, lt_d;
   logic [DATA_W-1:0] res_q_d, res_r_d;
   logic              busy_d, done_d;

   logic [DATA_W-1:0] seq_in1, seq_in2;
   logic [CTL_W-1:0]  seq_ctl;

   assign ex_result = alu_result;

   alu_port_mux u_port_mux (
      .seq_own (state_q != IDLE),
      .ex_in1  (ex_in1),
      .ex_in2  (ex_in2),
      .ex_ctl  (ex_ctl),
      .seq_in1 (seq_in1),
      .seq_in2 (seq_in2),
      .seq_ctl (seq_ctl),
      .alu_in1 (alu_in1),
      .alu_in2 (alu_in2),
      .alu_ctl (alu_ctl)
   );

   // Next-state, datapath and ALU drive; results are loaded on the edge entering DONE
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      lt_d    = lt_q;
      res_q_d = res_q;
      res_r_d = res_r;
      seq_in1 = '0;
      seq_in2 = '0;
      seq_ctl = ALU_ADD;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d   = opa;
               b_d   = opb;
               acc_d = '0;
               quo_d = '0;
               cnt_d = '0;
               if (!op_div) begin
                  state_d = MUL;
               end else if (opb == '0) begin
                  state_d = DONE;
                  res_q_d = '1;
                  res_r_d = opa;
               end else begin
                  state_d = DIV_CMP;
               end
            end
         end
         MUL: begin
            seq_in1 = acc_q;
            seq_in2 = a_q;
            seq_ctl = ALU_ADD;
            if (b_q[0]) acc_d = alu_result;
            a_d   = a_q << 1;
            b_d   = b_q >> 1;
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
               state_d = DONE;
               res_q_d = acc_d;
               res_r_d = '0;
            end
         end
         DIV_CMP: begin
            seq_in1 = {acc_q[DATA_W-2:0], a_q[DATA_W-1]};
            seq_in2 = b_q;
            seq_ctl = ALU_SLT;
            acc_d   = seq_in1;
            ovf_d   = acc_q[DATA_W-1];
            lt_d    = alu_result[0];
            a_d     = a_q << 1;
            state_d = DIV_SUB;
         end
         DIV_SUB: begin
            seq_in1 = acc_q;
            seq_in2 = b_q;
            seq_ctl = ALU_SUB;
            // A lost 17th remainder bit means the shifted value exceeds any divisor
            if (ovf_q || !lt_q) begin
               acc_d = alu_result;
               quo_d = {quo_q[DATA_W-2:0], 1'b1};
            end else begin
               quo_d = {quo_q[DATA_W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (&cnt_q) begin
               state_d = DONE;
               res_q_d = quo_d;
               res_r_d = acc_d;
            end else begin
               state_d = DIV_CMP;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         lt_q    <= 1'b0;
         res_q   <= '0;
         res_r   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         lt_q    <= lt_d;
         res_q   <= res_q_d;
         res_r   <= res_r_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

endmodule
